reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port register file with same-cycle write bypass, asynchronous clear, and an integrated busy-bit scoreboard. It sits in the decode stage of the pipelined datapath. Operand reads return either the committed value or the value being written this cycle. The scoreboard marks destinations issued but not yet written back so hazard logic can stall.

## Interface
Parameters:
- WIDTH, 8, data width of each register
- DEPTH, 8, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 is hardwired to 0 and never busy

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  WIDTH  writeback data
- ra  in  NREAD*AW  read addresses, port k at [k*AW +: AW]
- rd  out  NREAD*WIDTH  read data, port k at [k*WIDTH +: WIDTH]
- rd_busy  out  NREAD  port k operand has an outstanding producer
- iss_valid  in  1  an instruction issues this cycle
- iss_rd  in  AW  destination of the issuing instruction
- flush  in  1  clear all busy bits (pipeline flush)
- busy_cnt  out  $clog2(DEPTH+1)  number of registers currently busy

## Operation
- Reset (reset_n=0, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. Outputs therefore read rd = 0, rd_busy = 0 while reset is held.
- Write: on posedge, if we and not (ZERO_REG and wa==0), regs[wa] <= wd.
- Read, per port k, combinational:
  - rd = 0 if ZERO_REG and ra_k==0.
  - Else rd = wd if we and wa==ra_k (bypass).
  - Else rd = regs[ra_k].
- Busy bits, per register i, on posedge, priority high to low:
  - flush → 0.
  - iss_valid and iss_rd==i → 1 (set wins over same-cycle writeback to i).
  - we and wa==i → 0.
  - Otherwise hold.
- ZERO_REG=1: busy[0] is constant 0; issues and writes to register 0 are ignored.
- rd_busy_k = busy[ra_k] and not (we and wa==ra_k). A same-cycle writeback resolves the hazard. It reflects state before this cycle's issue.
- Writeback to a non-busy register is legal: data is written and busy is unchanged.
- busy_cnt is a registered population count of busy bits. It is updated incrementally: +1 on a set of a clear bit, -1 on a clear of a set bit, net per cycle. It goes to 0 on flush.
- Flush does not affect register contents or a same-cycle write.

## Timing
- Read latency 0 (combinational). A written value is visible through bypass in the write cycle and from the array in following cycles.
- Busy set by issue in cycle N is visible on rd_busy from cycle N+1.
- busy_cnt is valid one cycle after the event, with no glitches on the output.
- Simultaneous issue and writeback to the same register: the register is written and stays busy.
- Simultaneous flush and issue: flush wins, all busy bits are 0 next cycle.
- Deasserting reset mid-operation: state stays cleared and the first posedge after release acts normally.
- Multiple read ports with the same address return identical data and busy.

## Structure
- Package reg_file_pkg holds the default WIDTH/DEPTH/NREAD constants and a helper function for the busy_cnt width.
- Sub-module reg_scoreboard (busy vector, set/clear/flush priority, busy_cnt) is parameterised by DEPTH and ZERO_REG. The top level holds the storage array, the bypass muxes, and the rd_busy gating.

## Test plan
- Reset then read all ports at all addresses → rd=0, rd_busy=0, busy_cnt=0. Assert reset_n=0 mid-run after writes → immediate rd=0, busy_cnt=0.
- we=1, wa=3, wd=8'hA5, ra0=3 in the same cycle → rd0=8'hA5 that cycle and after. With wa=0 and wd=8'hFF → rd reads 0 at address 0.
- Issue iss_rd=5, then reading ra1=5 → rd_busy1=1 from the next cycle, busy_cnt=1. Writeback wa=5 → rd_busy1=0 in the writeback cycle, busy_cnt=0 the next cycle.
- Same cycle iss_rd=2 and we, wa=2, wd=8'h11 → register 2 reads 8'h11, busy[2] stays 1, busy_cnt increments by 1.
- Issue registers 1..7 on consecutive cycles → busy_cnt=7. flush together with iss_rd=4 → busy_cnt=0, all rd_busy=0 next cycle.
- NREAD=4, DEPTH=16, WIDTH=32 with all ports at address 9 during a write to 9 → all four rd equal wd, and all rd_busy=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and sizing helpers for the decode-stage register file.
package reg_file_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_NREAD = 2;

  // Width of a counter that can hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an issued, not yet
// written-back destination, plus a registered count of busy registers.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          iss_valid,
  input  logic [$clog2(DEPTH)-1:0]      iss_rd,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      wa,
  input  logic                          flush,
  output logic [DEPTH-1:0]              busy,
  output logic [cnt_width(DEPTH)-1:0]   busy_cnt
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic             set_ok;
  logic             clr_ok;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Flush beats issue; issue beats a same-register writeback.
  always_comb begin
    set_ok   = iss_valid && !(ZERO_REG && (iss_rd == '0));
    clr_ok   = we && !(ZERO_REG && (wa == '0));
    inc      = set_ok && !busy[iss_rd];
    dec      = clr_ok && busy[wa] && !(set_ok && (iss_rd == wa));
    busy_nxt = busy;
    cnt_nxt  = busy_cnt + CW'(inc) - CW'(dec);
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      if (clr_ok) busy_nxt[wa]     = 1'b0;
      if (set_ok) busy_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with same-cycle write bypass and an
// integrated busy scoreboard for decode-stage hazard detection.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              we,
  input  logic [$clog2(DEPTH)-1:0]          wa,
  input  logic [WIDTH-1:0]                  wd,
  input  logic [NREAD*$clog2(DEPTH)-1:0]    ra,
  output logic [NREAD*WIDTH-1:0]            rd,
  output logic [NREAD-1:0]                  rd_busy,
  input  logic                              iss_valid,
  input  logic [$clog2(DEPTH)-1:0]          iss_rd,
  input  logic                              flush,
  output logic [cnt_width(DEPTH)-1:0]       busy_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_ok;

  assign wr_ok = we && !(ZERO_REG && (wa == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // A same-cycle writeback both forwards its data and resolves the hazard.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             hit;
    logic [WIDTH-1:0] data;

    assign addr = ra[k*AW +: AW];
    assign hit  = we && (wa == addr);
    assign data = (ZERO_REG && (addr == '0)) ? '0 :
                  hit                        ? wd : regs[addr];
    assign rd[k*WIDTH +: WIDTH] = data;
    assign rd_busy[k]           = busy[addr] && !hit;
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we        (we),
    .wa        (wa),
    .flush     (flush),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, reset and
// wide-configuration sequences, and randomized traffic against a model.
module tb_reg_file_sb;

  localparam int unsigned W  = 8,  D  = 8,  N  = 2, AW  = 3, CW  = 4;
  localparam int unsigned W4 = 32, D4 = 16, N4 = 4, AW4 = 4, CW4 = 5;

  logic clk = 1'b0;
  logic reset_n;

  logic          we, iss_valid, flush;
  logic [AW-1:0] wa, iss_rd;
  logic [W-1:0]  wd;
  logic [N*AW-1:0] ra;
  logic [N*W-1:0]  rd;
  logic [N-1:0]    rd_busy;
  logic [CW-1:0]   busy_cnt;

  logic           we4, iss_valid4, flush4;
  logic [AW4-1:0] wa4, iss_rd4;
  logic [W4-1:0]  wd4;
  logic [N4*AW4-1:0] ra4;
  logic [N4*W4-1:0]  rd4;
  logic [N4-1:0]     rd_busy4;
  logic [CW4-1:0]    busy_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(W), .DEPTH(D), .NREAD(N), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd), .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  reg_file_sb #(.WIDTH(W4), .DEPTH(D4), .NREAD(N4), .ZERO_REG(1'b1)) dut4 (
    .clk(clk), .reset_n(reset_n), .we(we4), .wa(wa4), .wd(wd4), .ra(ra4),
    .rd(rd4), .rd_busy(rd_busy4), .iss_valid(iss_valid4), .iss_rd(iss_rd4),
    .flush(flush4), .busy_cnt(busy_cnt4)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra0, ra1;
    logic          iss;
    logic [AW-1:0] isr;
    logic          flush;
    logic [W-1:0]  e_rd0, e_rd1;
    logic [N-1:0]  e_busy;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: architectural contents and the set of pending producers.
  logic [W-1:0] m_regs [D];
  bit           m_busy [D];

  function automatic void model_reset();
    for (int i = 0; i < int'(D); i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < int'(D); i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    return m_busy[a] && !(we && wa == a);
  endfunction

  function automatic void model_clock();
    if (we && wa != 0) m_regs[wa] = wd;
    if (flush) begin
      for (int i = 0; i < int'(D); i++) m_busy[i] = 1'b0;
    end else begin
      if (we && wa != 0) m_busy[wa] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endfunction

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                              input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                              input logic i, input logic [AW-1:0] ir, input logic f,
                              input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [N-1:0] eb, input logic [CW-1:0] ec);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.ra0 = r0; v.ra1 = r1;
    v.iss = i; v.isr = ir; v.flush = f;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we = v.we; wa = v.wa; wd = v.wd; ra = {v.ra1, v.ra0};
    iss_valid = v.iss; iss_rd = v.isr; flush = v.flush;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_clock();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, " rd0"}, 32'(rd[0 +: W]), 32'(model_rd(ra[0 +: AW])));
    check({tag, " rd1"}, 32'(rd[W +: W]), 32'(model_rd(ra[AW +: AW])));
    check({tag, " busy"}, 32'(rd_busy),
          32'({model_busy(ra[AW +: AW]), model_busy(ra[0 +: AW])}));
    check({tag, " cnt"}, 32'(busy_cnt), 32'(model_cnt()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    drive(idle);
    we4 = 0; wa4 = '0; wd4 = '0; ra4 = '0; iss_valid4 = 0; iss_rd4 = '0; flush4 = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset held: every address reads zero and idle.
    for (int a = 0; a < int'(D); a++) begin
      ra = {AW'(int'(D) - 1 - a), AW'(a)};
      #1;
      check($sformatf("rst a%0d rd", a), 32'(rd), 32'(0));
      check($sformatf("rst a%0d busy", a), 32'(rd_busy), 32'(0));
      check($sformatf("rst a%0d cnt", a), 32'(busy_cnt), 32'(0));
      @(negedge clk);
    end
    reset_n = 1'b1;
    @(negedge clk);

    //                we wa wd     ra0 ra1 iss isr fl  rd0    rd1    busy   cnt
    vecs.push_back(mk(0, 0, 8'h00, 0, 7, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0));
    vecs.push_back(mk(1, 3, 8'hA5, 3, 3, 0, 0, 0, 8'hA5, 8'hA5, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 0, 0, 0, 0, 8'hA5, 8'h00, 2'b00, 0));
    vecs.push_back(mk(1, 0, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 3, 0, 0, 0, 8'h00, 8'hA5, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 5, 5, 1, 5, 0, 8'h00, 8'h00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 5, 0, 0, 0, 8'hA5, 8'h00, 2'b10, 1));
    vecs.push_back(mk(1, 5, 8'h3C, 5, 5, 0, 0, 0, 8'h3C, 8'h3C, 2'b00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 5, 5, 0, 0, 0, 8'h3C, 8'h3C, 2'b00, 0));
    vecs.push_back(mk(1, 2, 8'h11, 2, 2, 1, 2, 0, 8'h11, 8'h11, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2, 5, 0, 0, 0, 8'h11, 8'h3C, 2'b01, 1));
    vecs.push_back(mk(1, 2, 8'h22, 2, 1, 0, 0, 0, 8'h22, 8'h00, 2'b00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 2, 2, 0, 0, 0, 8'h22, 8'h22, 2'b00, 0));
    for (int j = 1; j <= 7; j++)
      vecs.push_back(mk(0, 0, 8'h00, 1, 7, 1, AW'(j), 0, 8'h00, 8'h00,
                        (j > 1) ? 2'b01 : 2'b00, CW'(j - 1)));
    vecs.push_back(mk(0, 0, 8'h00, 4, 7, 1, 4, 1, 8'h00, 8'h00, 2'b11, 7));
    vecs.push_back(mk(0, 0, 8'h00, 4, 7, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3, 3, 1, 3, 0, 8'hA5, 8'hA5, 2'b00, 0));
    vecs.push_back(mk(1, 6, 8'h77, 3, 6, 0, 0, 0, 8'hA5, 8'h77, 2'b01, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3, 6, 0, 0, 0, 8'hA5, 8'h77, 2'b01, 1));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d rd0", i), 32'(rd[0 +: W]), 32'(vecs[i].e_rd0));
      check($sformatf("vec%0d rd1", i), 32'(rd[W +: W]), 32'(vecs[i].e_rd1));
      check($sformatf("vec%0d busy", i), 32'(rd_busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d cnt", i), 32'(busy_cnt), 32'(vecs[i].e_cnt));
      tick();
    end

    // Asynchronous reset mid-run clears outputs immediately.
    drive(mk(0, 0, 8'h00, 2, 3, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_model("pre_rst");
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst rd", 32'(rd), 32'(0));
    check("midrst busy", 32'(rd_busy), 32'(0));
    check("midrst cnt", 32'(busy_cnt), 32'(0));
    model_reset();
    drive(mk(1, 2, 8'h99, 2, 3, 1, 4, 0, 0, 0, 0, 0));
    tick();
    reset_n = 1'b1;
    drive(mk(1, 3, 8'h5A, 3, 2, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("post_rst byp rd0", 32'(rd[0 +: W]), 32'(8'h5A));
    check("post_rst rd1", 32'(rd[W +: W]), 32'(0));
    check("post_rst cnt", 32'(busy_cnt), 32'(0));
    tick();
    drive(mk(0, 0, 8'h00, 3, 2, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("post_rst2 rd0", 32'(rd[0 +: W]), 32'(8'h5A));
    check_model("post_rst2");
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      we        = ($urandom_range(0, 1) == 1);
      wa        = AW'($urandom_range(0, D - 1));
      wd        = W'($urandom);
      ra        = {AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1))};
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = AW'($urandom_range(0, D - 1));
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      check_model($sformatf("rand%0d", c));
      tick();
    end
    drive(idle);

    // Wide configuration: four ports on one address during write and issue.
    iss_valid4 = 1; iss_rd4 = AW4'(9); ra4 = {N4{AW4'(9)}};
    #1;
    check("w4 pre busy", 32'(rd_busy4), 32'(0));
    check("w4 pre cnt", 32'(busy_cnt4), 32'(0));
    @(posedge clk); @(negedge clk);
    iss_valid4 = 0;
    #1;
    check("w4 busy set", 32'(rd_busy4), 32'(4'hF));
    check("w4 cnt1", 32'(busy_cnt4), 32'(1));
    @(posedge clk); @(negedge clk);
    we4 = 1; wa4 = AW4'(9); wd4 = 32'hDEAD_BEEF;
    #1;
    for (int k = 0; k < int'(N4); k++)
      check($sformatf("w4 byp rd%0d", k), rd4[k*W4 +: W4], 32'hDEAD_BEEF);
    check("w4 byp busy", 32'(rd_busy4), 32'(0));
    check("w4 byp cnt", 32'(busy_cnt4), 32'(1));
    @(posedge clk); @(negedge clk);
    we4 = 0;
    #1;
    for (int k = 0; k < int'(N4); k++)
      check($sformatf("w4 arr rd%0d", k), rd4[k*W4 +: W4], 32'hDEAD_BEEF);
    check("w4 arr busy", 32'(rd_busy4), 32'(0));
    check("w4 arr cnt", 32'(busy_cnt4), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
